// File: rtl/sbox_pkg.sv
// Shared definitions for the time-multiplexed substitution layer:
// FSM states, nibble width and a reference S-box table.
package sbox_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUB     = 2'd1,
    RND_END = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Reference mapping x -> r; the datapath itself uses sbox instances.
  localparam logic [3:0] SBOX_TBL [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

endpackage

// File: rtl/sbox.sv
// 4-bit substitution box, combinational x -> r.
module sbox (
  input  logic [3:0] x,
  output logic [3:0] r
);

  always_comb begin
    r = 4'h0;
    case (x)
      4'h0: r = 4'hC;
      4'h1: r = 4'h5;
      4'h2: r = 4'h6;
      4'h3: r = 4'hB;
      4'h4: r = 4'h9;
      4'h5: r = 4'h0;
      4'h6: r = 4'hA;
      4'h7: r = 4'hD;
      4'h8: r = 4'h3;
      4'h9: r = 4'hE;
      4'hA: r = 4'hF;
      4'hB: r = 4'h8;
      4'hC: r = 4'h4;
      4'hD: r = 4'h7;
      4'hE: r = 4'h1;
      4'hF: r = 4'h2;
    endcase
  end

endmodule

// File: rtl/sbox_lane_mux.sv
// LANES sbox instances fed from nibble group idx of the state; the
// substituted group is merged back into an otherwise unchanged next state.
module sbox_lane_mux
  import sbox_pkg::*;
#(
  parameter int BLOCK_W = 64,
  parameter int LANES   = 4,
  parameter int IDX_W   = 1
) (
  input  logic [BLOCK_W-1:0] state_i,
  input  logic [IDX_W-1:0]   idx_i,
  output logic [BLOCK_W-1:0] next_o
);

  localparam int GW = LANES * NIB_W;
  localparam int G  = BLOCK_W / GW;

  logic [GW-1:0] grp_in, grp_out;

  always_comb begin
    grp_in = '0;
    for (int g = 0; g < G; g++)
      if (idx_i == IDX_W'(g)) grp_in = state_i[g*GW +: GW];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox u_sbox (
      .x(grp_in[l*NIB_W +: NIB_W]),
      .r(grp_out[l*NIB_W +: NIB_W])
    );
  end

  always_comb begin
    next_o = state_i;
    for (int g = 0; g < G; g++)
      if (idx_i == IDX_W'(g)) next_o[g*GW +: GW] = grp_out;
  end

endmodule

// File: rtl/sbox_layer_ctrl.sv
// Substitution-layer engine: key XOR, LANES-wide S-box sweep over all nibble
// groups, rotation, repeated ROUNDS times, with valid/ready on both sides.
module sbox_layer_ctrl
  import sbox_pkg::*;
#(
  parameter int BLOCK_W = 64,
  parameter int LANES   = 4,
  parameter int ROUNDS  = 1,
  parameter int ROT     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic [BLOCK_W-1:0] in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
);

  localparam int G     = BLOCK_W / (NIB_W * LANES);
  localparam int IDX_W = (G > 1) ? $clog2(G) : 1;
  localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(G - 1);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);

  state_e             fsm_q, fsm_d;
  logic [BLOCK_W-1:0] st_q, st_d, key_q, key_d, sub_nxt, rot_s;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [RND_W-1:0]   rnd_q, rnd_d;

  sbox_lane_mux #(
    .BLOCK_W(BLOCK_W),
    .LANES  (LANES),
    .IDX_W  (IDX_W)
  ) u_mux (
    .state_i(st_q),
    .idx_i  (idx_q),
    .next_o (sub_nxt)
  );

  // With ROT=0 the right shift spans the full width and contributes zero.
  assign rot_s = (st_q << ROT) | (st_q >> (BLOCK_W - ROT));

  always_comb begin
    fsm_d = fsm_q;
    st_d  = st_q;
    key_d = key_q;
    idx_d = idx_q;
    rnd_d = rnd_q;
    case (fsm_q)
      IDLE: if (in_valid) begin
        st_d  = in_data ^ in_key;
        key_d = in_key;
        idx_d = '0;
        rnd_d = '0;
        fsm_d = SUB;
      end
      SUB: begin
        st_d = sub_nxt;
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
          fsm_d = RND_END;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RND_END: if (rnd_q == RND_LAST) begin
        st_d  = rot_s;
        fsm_d = DONE;
      end else begin
        st_d  = rot_s ^ key_q;
        rnd_d = rnd_q + 1'b1;
        fsm_d = SUB;
      end
      DONE: if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      st_q  <= '0;
      key_q <= '0;
      idx_q <= '0;
      rnd_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      st_q  <= st_d;
      key_q <= key_d;
      idx_q <= idx_d;
      rnd_q <= rnd_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  assign out_data  = st_q;

endmodule

// File: tb/tb_sbox_layer_ctrl.sv
// Scoreboard bench: two engine configs (1 round/no rotate, 2 rounds/rotate 4)
// checked against a nibble-wise reference model of the substitution rounds.
module tb_sbox_layer_ctrl;
  import sbox_pkg::*;

  localparam int W = 16;
  localparam int RN  [2] = '{1, 2};
  localparam int RT  [2] = '{0, 4};
  localparam int LAT [2] = '{3, 6};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]   in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] in_data [2];
  logic [W-1:0] in_key  [2];
  logic [W-1:0] out_data[2];

  sbox_layer_ctrl #(.BLOCK_W(W), .LANES(2), .ROUNDS(1), .ROT(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_key(in_key[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .busy(busy[0])
  );

  sbox_layer_ctrl #(.BLOCK_W(W), .LANES(2), .ROUNDS(2), .ROT(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_key(in_key[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .busy(busy[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [W-1:0] exp_d[2][$];
  int           exp_c[2][$];
  bit rand_bp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    chk_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
  endtask

  function automatic logic [W-1:0] model(input int u, input logic [W-1:0] d, input logic [W-1:0] k);
    logic [W-1:0] s;
    logic [3:0]   x;
    s = d ^ k;
    for (int r = 0; r < RN[u]; r++) begin
      for (int n = 0; n < W / 4; n++) begin
        x = s[n*4 +: 4];
        s[n*4 +: 4] = SBOX_TBL[x];
      end
      for (int b = 0; b < RT[u]; b++) s = {s[W-2:0], s[W-1]};
      if (r != RN[u] - 1) s = s ^ k;
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one block; returns the cycle number of the accepting edge.
  task automatic send(input int u, input logic [W-1:0] d, input logic [W-1:0] k,
                      input logic [W-1:0] expv, input bit hold, output int acc);
    int n;
    in_valid[u] = 1'b1;
    in_data[u]  = d;
    in_key[u]   = k;
    for (n = 0; n < 200; n++) begin
      if (in_ready[u] && !rst) break;
      tick();
    end
    if (n == 200) begin
      chk("accept_timeout", 32'(n), 32'd0);
      in_valid[u] = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    exp_d[u].push_back(expv);
    exp_c[u].push_back(acc + LAT[u]);
    tick();
    if (!hold) in_valid[u] = 1'b0;
    in_data[u] = W'($urandom);
    in_key[u]  = W'($urandom);
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 500; n++) begin
      if (exp_d[0].size() == 0 && exp_d[1].size() == 0 && busy == 2'b00) break;
      tick();
    end
    chk("drain_pending", 32'(exp_d[0].size() + exp_d[1].size()), 32'd0);
  endtask

  // Monitor: latency on each out_valid rise, data on each output handshake.
  logic [1:0] prev_v = 2'b00;
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) prev_v[u] = 1'b0;
      else begin
        if (out_valid[u] && !prev_v[u]) begin
          if (exp_c[u].size() == 0) chk($sformatf("unexpected_out%0d", u), 32'd1, 32'd0);
          else chk($sformatf("latency%0d", u), 32'(cyc), 32'(exp_c[u][0]));
        end
        if (out_valid[u] && out_ready[u] && exp_d[u].size() > 0) begin
          chk($sformatf("data%0d", u), 32'(out_data[u]), 32'(exp_d[u].pop_front()));
          void'(exp_c[u].pop_front());
        end
        prev_v[u] = out_valid[u];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_bp) out_ready = 2'($urandom_range(0, 3));
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, prev_acc;
    logic [W-1:0] d, k, held;
    bit saw;
    in_valid  = 2'b00;
    out_ready = 2'b11;
    for (int u = 0; u < 2; u++) begin
      in_data[u] = '0;
      in_key[u]  = '0;
    end

    // Reset: in_ready high, nothing accepted even with in_valid asserted.
    rst = 1'b1;
    tick();
    in_valid[0] = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'h3);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    in_valid[0] = 1'b0;
    rst = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 32'h0);

    // Directed vectors
    send(0, 16'h0123, 16'h0000, 16'hC56B, 1'b0, acc);
    drain();
    send(0, 16'h0123, 16'hFFFF, 16'h2174, 1'b0, acc);
    drain();
    send(1, 16'h0000, 16'h0000, 16'h4444, 1'b0, acc);
    drain();

    // Backpressure
    out_ready[0] = 1'b0;
    send(0, 16'h0123, 16'h0000, 16'hC56B, 1'b0, acc);
    for (int n = 0; n < 50 && !out_valid[0]; n++) tick();
    chk("bp_valid", 32'(out_valid[0]), 32'd1);
    held = out_data[0];
    in_valid[0] = 1'b1;
    in_data[0]  = 16'hBEEF;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("bp_stable", 32'(out_data[0]), 32'(held));
      chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
      chk("bp_busy", 32'(busy[0]), 32'd1);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    chk("bp_release_ready", 32'(in_ready[0]), 32'd1);
    chk("bp_release_valid", 32'(out_valid[0]), 32'd0);
    tick();
    chk("bp_no_accept", 32'(busy[0]), 32'd0);

    // Reset while the block is in SUB
    send(0, 16'h5A5A, 16'h1234, model(0, 16'h5A5A, 16'h1234), 1'b0, acc);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_d[0].delete();
    exp_c[0].delete();
    saw = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (out_valid[0]) saw = 1'b1;
    end
    chk("rst_abandon", 32'(saw), 32'd0);
    chk("rst_ready_again", 32'(in_ready[0]), 32'd1);
    send(0, 16'h0123, 16'h0000, 16'hC56B, 1'b0, acc);
    drain();

    // Back-to-back with in_valid held high
    prev_acc = -1;
    for (int i = 0; i < 3; i++) begin
      d = W'($urandom);
      k = W'($urandom);
      send(0, d, k, model(0, d, k), 1'b1, acc);
      if (i > 0) chk("b2b_spacing", 32'(acc - prev_acc), 32'd5);
      prev_acc = acc;
    end
    in_valid[0] = 1'b0;
    drain();

    // Random blocks on both configs with random output backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 24; i++) begin
      int u;
      u = int'($urandom_range(0, 1));
      d = W'($urandom);
      k = W'($urandom);
      send(u, d, k, model(u, d, k), 1'b0, acc);
    end
    rand_bp = 1'b0;
    tick();
    out_ready = 2'b11;
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sbox_layer_ctrl.md
Name: sbox_layer_ctrl

Overview:
Time-multiplexed substitution-layer engine built around the existing 4-bit `sbox` module (ports `x`, `r`). It instantiates LANES `sbox` copies and sequences them over all nibbles of a BLOCK_W-bit word. It applies ROUNDS rounds of key-XOR, substitution and rotation. A valid/ready handshake sits on both input and output, so the block drops into a cipher datapath without needing a full-width S-box array.

Parameters:
BLOCK_W, 64, data/key width in bits; must be a multiple of 4.
LANES, 4, number of `sbox` instances used per cycle; (BLOCK_W/4) must be divisible by LANES.
ROUNDS, 1, substitution rounds per block; must be at least 1.
ROT, 0, left-rotate amount in bits applied at each round end; must be less than BLOCK_W.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input block valid
in_ready  out  1  engine can accept a block
in_data  in  BLOCK_W  plaintext/state in
in_key  in  BLOCK_W  round key; captured at acceptance
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  BLOCK_W  result
busy  out  1  block in flight (any state except IDLE)

Behaviour:
- Clocking and reset: single clock `clk`; reset `rst` is synchronous, active-high.
- Reset: FSM goes to IDLE; idx=0, rnd=0, state register=0, out_valid=0, busy=0.
  - in_ready=1 from the first edge with `rst` high onward, but no acceptance occurs while `rst`=1.
  - Reset mid-operation abandons the block; no out_valid is produced for it.
- Derived constants: G = BLOCK_W/(4*LANES) lane groups per round; group i covers nibbles i*LANES .. i*LANES+LANES-1 (nibble 0 = bits 3:0).
- FSM states: IDLE, SUB, RND_END, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state <= in_data^in_key; key_q <= in_key; idx <= 0; rnd <= 0; go to SUB.
- SUB:
  - Each cycle, replace nibbles of group idx with sbox(nibble); all other nibbles hold.
  - idx advances by 1 per cycle.
  - On the last group (idx==G-1): idx <= 0; go to RND_END.
- RND_END (1 cycle):
  - Let t = rotl(state, ROT).
  - If rnd==ROUNDS-1: state <= t; go to DONE.
  - Otherwise: state <= t^key_q; rnd++; go to SUB.
- DONE:
  - out_valid=1; out_data=state, held stable until out_valid&&out_ready.
  - On that handshake: go to IDLE; out_valid drops next cycle.
- Latency: out_valid rises exactly ROUNDS*(G+1) clock edges after the accepting edge.
- No overlap: in_ready=0 in SUB, RND_END and DONE, including the handshake cycle; in_ready=1 again in the cycle after the output handshake.
- Combinational paths: none from in_* to out_*; in_ready and out_valid decode directly from the FSM state.
- Counter widths: idx is clog2(G) bits (min 1); rnd is clog2(ROUNDS) bits (min 1). No wrap beyond G-1 / ROUNDS-1.
- Inputs ignored outside the IDLE acceptance: in_data and in_key changes have no effect; out_ready is ignored outside DONE.
- S-box mapping x->r (hex), used by both sides to check results:
  - 0->C, 1->5, 2->6, 3->B, 4->9, 5->0, 6->A, 7->D
  - 8->3, 9->E, A->F, B->8, C->4, D->7, E->1, F->2

Decomposition:
- Shared package `sbox_pkg`:
  - FSM state enum (IDLE/SUB/RND_END/DONE).
  - Nibble width constant (4).
  - S-box reference table as a constant array, for the bench scoreboard only; the RTL must use `sbox` instances.
- Sub-module: `sbox_lane_mux`, holding the LANES `sbox` instances. Its read mux selects group idx from the state; its write-back merge produces the next state.
- The top level keeps the FSM, counters, rotation and handshakes.

Test Plan:
1. BLOCK_W=16, LANES=2, ROUNDS=1, ROT=0; in_data=0x0123, key=0x0000 -> out_data=0xC56B; out_valid 3 edges after acceptance.
2. Same config; in_data=0x0123, key=0xFFFF -> out_data=0x2174.
3. BLOCK_W=16, LANES=2, ROUNDS=2, ROT=4; in_data=0x0000, key=0x0000 -> out_data=0x4444; latency 6 edges.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, busy=1; a new in_valid pulse is not accepted; after out_ready=1, in_ready=1 the next cycle.
5. Reset mid-operation: assert `rst` for 1 cycle during SUB -> out_valid never rises for that block; next block 0x0123/key 0 -> 0xC56B with normal latency.
6. Back-to-back: in_valid held high with 3 blocks and out_ready=1 -> blocks accepted every 5 cycles (3 busy + DONE + IDLE); results match the scoreboard in order.
